// File: rtl/alu_share_pkg.sv
// Shared definitions for the shared-ALU controller: ALU opcodes, FSM states and NZCV bit positions.
package alu_share_pkg;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    // Arithmetic ops own C and V; logical ops leave them to the previous value.
    function automatic logic writes_cv(input logic [1:0] op);
        return (op == ALU_ADD) || (op == ALU_SUB);
    endfunction

endpackage

// File: rtl/alu_share_alu.sv
// Combinational 2-bit-opcode ALU (ADD/SUB/AND/ORR) producing a WIDTH-bit result and raw NZCV flags.
module alu_share_alu
    import alu_share_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_result,
    output logic [3:0]       o_flags
);

    logic             w_is_sub;
    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH:0]   w_sum;

    // SUB is A + ~B + 1, so the carry out is the NOT-borrow flag.
    assign w_is_sub = (i_op == ALU_SUB);
    assign w_b_eff  = w_is_sub ? ~i_b : i_b;
    assign w_sum    = {1'b0, i_a} + {1'b0, w_b_eff} + (WIDTH+1)'(w_is_sub);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        o_result = '0;
        o_flags  = '0;
        unique case (i_op)
            ALU_ADD, ALU_SUB: begin
                o_result        = w_sum[WIDTH-1:0];
                o_flags[FLAG_C] = w_sum[WIDTH];
                o_flags[FLAG_V] = (i_a[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                                  (w_sum[WIDTH-1] != i_a[WIDTH-1]);
            end
            ALU_AND: o_result = i_a & i_b;
            default: o_result = i_a | i_b;
        endcase
        o_flags[FLAG_N] = o_result[WIDTH-1];
        o_flags[FLAG_Z] = (o_result == '0);
    end

endmodule

// File: rtl/alu_share_arb2.sv
// Two-way one-hot grant logic; ALU_SHARE_RR_EN selects round-robin, otherwise fixed priority to rq0.
module arb2 (
    input  logic [1:0] req,
`ifdef ALU_SHARE_RR_EN
    input  logic       rr_last,
`endif
    output logic [1:0] gnt
);

`ifdef ALU_SHARE_RR_EN
    // On a tie the requester that was not served last wins.
    always_comb begin
        gnt = '0;
        if (req == 2'b11) begin
            gnt[~rr_last] = 1'b1;
        end else begin
            gnt = req;
        end
    end
`else
    assign gnt = {req[1] & ~req[0], req[0]};
`endif

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one ALU between two valid/ready requesters and owns the NZCV register.
// Build option ALU_SHARE_RR_EN: round-robin arbitration instead of fixed rq0 priority.
module alu_share_ctrl
    import alu_share_pkg::*;
#(
    parameter int         WIDTH     = 32,
    parameter logic [3:0] FLAGS_RST = 4'b0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [1:0]       req_op0,
    input  logic [1:0]       req_op1,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [WIDTH-1:0] req_b1,
    input  logic             req_sf0,
    input  logic             req_sf1,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       rsp_flags,
    output logic [3:0]       flags_q,
    output logic             busy
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       w_gnt;
    logic             w_accept;

    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_sf;
    logic             r_owner;

    logic [WIDTH-1:0] r_result;
    logic [3:0]       r_flags;
    logic [3:0]       r_flags_q;
    logic [WIDTH-1:0] w_alu_result;
    logic [3:0]       w_alu_flags;

`ifdef ALU_SHARE_RR_EN
    logic r_rr_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_last <= 1'b1;
        end else if (w_accept) begin
            r_rr_last <= w_gnt[1];
        end
    end
`endif

    arb2 u_arb (
        .req     (req_valid),
`ifdef ALU_SHARE_RR_EN
        .rr_last (r_rr_last),
`endif
        .gnt     (w_gnt)
    );

    alu_share_alu #(.WIDTH(WIDTH)) u_alu (
        .i_op     (r_op),
        .i_a      (r_a),
        .i_b      (r_b),
        .o_result (w_alu_result),
        .o_flags  (w_alu_flags)
    );

    assign w_accept = |req_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_accept) w_state_nxt = EXEC;
            EXEC:    w_state_nxt = RESP;
            RESP:    if (rsp_ready[r_owner]) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        busy      = 1'b1;
        unique case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (!reset) req_ready = w_gnt;
            end
            RESP:    if (!reset) rsp_valid[r_owner] = 1'b1;
            default: ;
        endcase
    end

    // NOTE: operand registers carry no reset; they are only read in EXEC, always after a load.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_owner <= w_gnt[1];
            r_op    <= w_gnt[1] ? req_op1 : req_op0;
            r_a     <= w_gnt[1] ? req_a1  : req_a0;
            r_b     <= w_gnt[1] ? req_b1  : req_b0;
            r_sf    <= w_gnt[1] ? req_sf1 : req_sf0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_result  <= '0;
            r_flags   <= '0;
            r_flags_q <= FLAGS_RST;
        end else if (r_state == EXEC) begin
            r_result <= w_alu_result;
            r_flags  <= w_alu_flags;
            if (r_sf) begin
                r_flags_q <= writes_cv(r_op) ? w_alu_flags :
                             {w_alu_flags[FLAG_N], w_alu_flags[FLAG_Z],
                              r_flags_q[FLAG_C], r_flags_q[FLAG_V]};
            end
        end
    end

    assign rsp_result = r_result;
    assign rsp_flags  = r_flags;
    assign flags_q    = r_flags_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed self-checking bench for alu_share_ctrl; expectations follow ALU_SHARE_RR_EN when defined.
module tb_alu_share_ctrl;

    localparam int         WIDTH     = 32;
    localparam logic [3:0] FLAGS_RST = 4'b0000;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0]       req_op0, req_op1;
    logic [WIDTH-1:0] req_a0, req_a1, req_b0, req_b1;
    logic             req_sf0, req_sf1;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic [3:0]       rsp_flags;
    logic [3:0]       flags_q;
    logic             busy;

    int n_tests = 0;
    int n_fail  = 0;

    alu_share_ctrl #(.WIDTH(WIDTH), .FLAGS_RST(FLAGS_RST)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op0    (req_op0),
        .req_op1    (req_op1),
        .req_a0     (req_a0),
        .req_a1     (req_a1),
        .req_b0     (req_b0),
        .req_b1     (req_b1),
        .req_sf0    (req_sf0),
        .req_sf1    (req_sf1),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags),
        .flags_q    (flags_q),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] onehot(input int rq);
        logic [1:0] v;
        v     = '0;
        v[rq] = 1'b1;
        return v;
    endfunction

    task automatic set_req(input int rq, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic sf);
        if (rq == 0) begin
            req_op0 = op; req_a0 = a; req_b0 = b; req_sf0 = sf;
        end else begin
            req_op1 = op; req_a1 = a; req_b1 = b; req_sf1 = sf;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One full transaction from a lone requester, checking latency, response and flag register.
    task automatic run_op(input string tag, input int rq, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b, input logic sf,
                          input logic [31:0] exp_res, input logic [3:0] exp_rf,
                          input logic [3:0] exp_fq);
        @(negedge clk);
        set_req(rq, op, a, b, sf);
        req_valid = onehot(rq);
        #1;
        check({tag, " grant"}, 64'(req_ready), 64'(onehot(rq)));
        @(negedge clk);
        req_valid = '0;
        set_req(rq, ~op, 32'hDEAD_BEEF, 32'h1234_5678, ~sf);
        #1;
        check({tag, " exec busy"}, 64'(busy), 64'd1);
        check({tag, " exec rsp_valid"}, 64'(rsp_valid), 64'd0);
        @(negedge clk);
        #1;
        check({tag, " rsp_valid"}, 64'(rsp_valid), 64'(onehot(rq)));
        check({tag, " result"}, 64'(rsp_result), 64'(exp_res));
        check({tag, " rsp_flags"}, 64'(rsp_flags), 64'(exp_rf));
        check({tag, " flags_q"}, 64'(flags_q), 64'(exp_fq));
        rsp_ready = onehot(rq);
        @(negedge clk);
        rsp_ready = '0;
        #1;
        check({tag, " idle busy"}, 64'(busy), 64'd0);
    endtask

    logic [1:0] exp_gnt [4];
    logic [1:0] exp_next;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        set_req(0, 2'b00, '0, '0, 1'b0);
        set_req(1, 2'b00, '0, '0, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst busy", 64'(busy), 64'd0);
        check("rst req_ready", 64'(req_ready), 64'd0);
        check("rst rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst result", 64'(rsp_result), 64'd0);
        check("rst rsp_flags", 64'(rsp_flags), 64'd0);
        check("rst flags_q", 64'(flags_q), 64'(FLAGS_RST));

        // Directed single-requester vectors.
        run_op("t1 add ovf", 0, 2'b00, 32'h7FFF_FFFF, 32'h1, 1'b1, 32'h8000_0000, 4'b1001, 4'b1001);
        run_op("t2 sub eq",  1, 2'b01, 32'd5, 32'd5, 1'b0, 32'h0, 4'b0110, 4'b1001);
        run_op("set cv",     0, 2'b01, 32'h8000_0000, 32'h1, 1'b1, 32'h7FFF_FFFF, 4'b0011, 4'b0011);
        run_op("t3 and",     0, 2'b10, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 1'b1, 32'h0, 4'b0100, 4'b0111);
        run_op("orr",        1, 2'b11, 32'h8000_0000, 32'h1, 1'b1, 32'h8000_0001, 4'b1000, 4'b1011);
        run_op("add wrap",   0, 2'b00, 32'hFFFF_FFFF, 32'h1, 1'b1, 32'h0, 4'b0110, 4'b0110);
        run_op("sub borrow", 1, 2'b01, 32'd3, 32'd5, 1'b1, 32'hFFFF_FFFE, 4'b1000, 4'b1000);

        // Both requesters valid every cycle, from a fresh reset.
`ifdef ALU_SHARE_RR_EN
        exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        exp_gnt = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
        do_reset();
        set_req(0, 2'b00, 32'd10, 32'd1, 1'b0);
        set_req(1, 2'b00, 32'd20, 32'd2, 1'b0);
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("t4 grant %0d", i), 64'(req_ready), 64'(exp_gnt[i]));
            @(negedge clk);
            @(negedge clk);
            #1;
            check($sformatf("t4 rsp_valid %0d", i), 64'(rsp_valid), 64'(exp_gnt[i]));
            check($sformatf("t4 result %0d", i), 64'(rsp_result),
                  exp_gnt[i][1] ? 64'd22 : 64'd11);
            @(negedge clk);
        end
        req_valid = '0;
        rsp_ready = '0;

        // Back-pressure in RESP with both requesters knocking.
        @(negedge clk);
        set_req(0, 2'b01, 32'd9, 32'd4, 1'b1);
        set_req(1, 2'b00, 32'd20, 32'd2, 1'b0);
        req_valid = 2'b01;
        #1;
        check("t5 grant", 64'(req_ready), 64'd1);
        @(negedge clk);
        req_valid = 2'b11;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("t5 hold valid %0d", k), 64'(rsp_valid), 64'd1);
            check($sformatf("t5 hold result %0d", k), 64'(rsp_result), 64'd5);
            check($sformatf("t5 hold flags %0d", k), 64'(rsp_flags), 64'(4'b0010));
            check($sformatf("t5 hold ready %0d", k), 64'(req_ready), 64'd0);
            check($sformatf("t5 hold busy %0d", k), 64'(busy), 64'd1);
            @(negedge clk);
        end
        rsp_ready = 2'b10;
        #1;
        check("t5 non-owner ready ignored", 64'(rsp_valid), 64'd1);
        rsp_ready = 2'b01;
        @(negedge clk);
        rsp_ready = '0;
`ifdef ALU_SHARE_RR_EN
        exp_next = 2'b10;
`else
        exp_next = 2'b01;
`endif
        #1;
        check("t5 next grant", 64'(req_ready), 64'(exp_next));
        check("t5 flags_q", 64'(flags_q), 64'(4'b0010));
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #1;
        check("t5 next rsp_valid", 64'(rsp_valid), 64'(exp_next));
        check("t5 next result", 64'(rsp_result), exp_next[1] ? 64'd22 : 64'd5);
        rsp_ready = 2'b11;
        @(negedge clk);
        rsp_ready = '0;

        // Reset during EXEC of a flag-setting SUB discards it.
        @(negedge clk);
        set_req(0, 2'b01, 32'd1, 32'd2, 1'b1);
        req_valid = 2'b01;
        @(negedge clk);
        req_valid = '0;
        #1;
        check("t6 in exec", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("t6 busy", 64'(busy), 64'd0);
        check("t6 rsp_valid", 64'(rsp_valid), 64'd0);
        check("t6 flags_q", 64'(flags_q), 64'(FLAGS_RST));
        check("t6 result", 64'(rsp_result), 64'd0);
        check("t6 rsp_flags", 64'(rsp_flags), 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check($sformatf("t6 no completion %0d", k), 64'(rsp_valid), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
